// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: data width and drain FSM states.
package uart_tx_fifo_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } drain_state_e;

endpackage : uart_tx_fifo_pkg

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the transmit FIFO: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                   clk_bus,
  input  logic                   we,
  input  logic [DEPTH_LOG2-1:0]  waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0]  raddr,
  output logic [UART_DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [UART_DATA_W-1:0] mem [DEPTH];

  // Storage is not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk_bus) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_tx_fifo.sv
// Bus-side transmit FIFO feeding the UART transmitter one byte per request/idle handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                   clk_bus,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   flush,
  input  logic                   ovf_clr,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   overflow,
  output logic                   all_sent,
  output logic                   tx_request,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_idle
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;

  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [UART_DATA_W-1:0] rd_byte_c;
  drain_state_e           state;
  logic                   push_c;
  logic                   pop_c;

  // Flags derived from the extra-bit pointers: equal means empty, MSB-only difference means full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                    (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign level    = wr_ptr - rd_ptr;
  assign all_sent = empty && (state == S_IDLE) && tx_idle;

  // Flush suppresses both sides; full is the pre-edge value so a pop cannot make room this cycle.
  assign push_c = wr_en && !full && !flush;
  assign pop_c  = (state == S_IDLE) && !empty && tx_idle && !flush;

  uart_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk_bus (clk_bus),
    .we      (push_c),
    .waddr   (wr_ptr[PW-2:0]),
    .wdata   (wr_data),
    .raddr   (rd_ptr[PW-2:0]),
    .rdata_c (rd_byte_c)
  );

  // Read/write pointers; flush returns both to zero.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Sticky overflow: a rejected write sets it and beats a simultaneous clear.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full && !flush) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Drain FSM: one-cycle request, then wait for the transmitter to report idle again.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tx_request <= 1'b0;
      tx_data    <= '0;
    end else begin
      tx_request <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop_c) begin
            tx_data    <= rd_byte_c;
            tx_request <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_idle) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed table, corner sequences and a random run
// compared against a queue-based reference model and a simple transmitter model.
module tb_uart_tx_fifo;

  localparam int unsigned DL2   = 4;
  localparam int unsigned DEPTH = 16;

  logic       clk_bus = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       ovf_clr;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       all_sent;
  logic       tx_request;
  logic [7:0] tx_data;
  logic       tx_idle;

  uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk_bus    (clk_bus),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .flush      (flush),
    .ovf_clr    (ovf_clr),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .all_sent   (all_sent),
    .tx_request (tx_request),
    .tx_data    (tx_data),
    .tx_idle    (tx_idle)
  );

  always #5 clk_bus = ~clk_bus;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue contents, sticky flag, last byte handed out, request handshake.
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_ready;
  bit         m_req;
  int         m_since;
  logic [7:0] m_data;

  // Transmitter model.
  bit         tx_override;
  int         busy_len;
  int         busy_cnt;
  bit         req_seen;
  logic [7:0] data_seen;
  logic [7:0] rx[$];
  int         req_count;

  typedef struct {
    bit         wr;
    logic [7:0] d;
    bit         fl;
    bit         clr;
    bit         idle;
    int         e_level;
    bit         e_req;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_ready = 1'b1;
    m_req   = 1'b0;
    m_since = 3;
    m_data  = 8'h00;
  endtask

  task automatic compare_all();
    int sz;
    sz = q.size();
    check("level",    32'(level),      32'(sz));
    check("full",     32'(full),       32'(sz == int'(DEPTH)));
    check("empty",    32'(empty),      32'(sz == 0));
    check("overflow", 32'(overflow),   32'(m_ovf));
    check("tx_req",   32'(tx_request), 32'(m_req));
    check("tx_data",  32'(tx_data),    32'(m_data));
    check("all_sent", 32'(all_sent),   32'(sz == 0 && m_ready && tx_idle));
  endtask

  // One bus cycle: drive inputs, advance the clock, update both models, compare everything.
  task automatic step(input bit w, input logic [7:0] d, input bit f, input bit c);
    bit p_idle;
    int pre_size;
    bit pop;
    wr_en   = w;
    wr_data = d;
    flush   = f;
    ovf_clr = c;
    p_idle  = tx_idle;
    pre_size = q.size();
    @(posedge clk_bus);
    #1;
    pop = m_ready && (pre_size != 0) && p_idle && !f;
    m_req = pop;
    if (pop) begin
      m_data  = q.pop_front();
      m_ready = 1'b0;
      m_since = 0;
    end else begin
      if (m_since < 3) m_since++;
      if (!m_ready && m_since >= 2 && p_idle) m_ready = 1'b1;
    end
    if (f) q.delete();
    else if (w && pre_size < int'(DEPTH)) q.push_back(d);
    if (w && pre_size == int'(DEPTH) && !f) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (req_seen) begin
      rx.push_back(data_seen);
      req_count++;
      if (!tx_override && busy_len > 0) begin
        tx_idle  = 1'b0;
        busy_cnt = busy_len;
      end
    end else if (!tx_override && busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_idle = 1'b1;
    end
    #1;
    compare_all();
    req_seen  = tx_request;
    data_seen = tx_data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0;
    tx_override = 1'b0; busy_len = 0; busy_cnt = 0;
    tx_idle = 1'b1; req_seen = 1'b0; data_seen = 8'h00;
    model_reset();
    #2;
    check("rst_level",    32'(level),      32'd0);
    check("rst_empty",    32'(empty),      32'd1);
    check("rst_full",     32'(full),       32'd0);
    check("rst_ovf",      32'(overflow),   32'd0);
    check("rst_req",      32'(tx_request), 32'd0);
    check("rst_data",     32'(tx_data),    32'h00);
    check("rst_all_sent", 32'(all_sent),   32'd1);
    @(posedge clk_bus);
    #2;
    rst_n = 1'b1;
    rx.delete();
    req_count = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Run idle cycles until the transmitter has received `want` bytes, bounded.
  task automatic drain_until(input int want, input int budget, input string name);
    int cyc;
    cyc = 0;
    while (rx.size() < want && cyc < budget) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      cyc++;
    end
    check(name, 32'(rx.size()), 32'(want));
  endtask

  initial begin
    logic [7:0] sent[$];
    int cyc;
    logic [7:0] b;

    // Directed table with tx_idle driven per row.
    tbl[0]  = '{1, 8'h11, 0, 0, 0, 1, 0, 8'h00};
    tbl[1]  = '{1, 8'h22, 0, 0, 0, 2, 0, 8'h00};
    tbl[2]  = '{0, 8'h00, 0, 1, 0, 2, 0, 8'h00};
    tbl[3]  = '{1, 8'h33, 1, 0, 0, 0, 0, 8'h00};
    tbl[4]  = '{1, 8'h44, 0, 0, 0, 1, 0, 8'h00};
    tbl[5]  = '{0, 8'h00, 0, 0, 0, 1, 0, 8'h00};
    tbl[6]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00};
    tbl[7]  = '{1, 8'h55, 0, 0, 1, 1, 0, 8'h00};
    tbl[8]  = '{0, 8'h00, 0, 0, 1, 0, 1, 8'h55};
    tbl[9]  = '{1, 8'h66, 0, 0, 1, 1, 0, 8'h55};
    tbl[10] = '{0, 8'h00, 0, 0, 0, 1, 0, 8'h55};
    tbl[11] = '{0, 8'h00, 0, 0, 1, 1, 0, 8'h55};
    tbl[12] = '{0, 8'h00, 0, 0, 1, 0, 1, 8'h66};

    do_reset();
    tx_override = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tx_idle = tbl[i].idle;
      step(tbl[i].wr, tbl[i].d, tbl[i].fl, tbl[i].clr);
      check($sformatf("tbl%0d_level", i), 32'(level),      32'(tbl[i].e_level));
      check($sformatf("tbl%0d_req", i),   32'(tx_request), 32'(tbl[i].e_req));
      check($sformatf("tbl%0d_data", i),  32'(tx_data),    32'(tbl[i].e_data));
    end

    // Single byte latency and all_sent.
    do_reset();
    busy_len = 3;
    step(1'b1, 8'h41, 1'b0, 1'b0);
    check("t1_req_early", 32'(tx_request), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t1_req",   32'(tx_request), 32'd1);
    check("t1_data",  32'(tx_data),    32'h41);
    check("t1_empty", 32'(empty),      32'd1);
    cyc = 0;
    while (!(all_sent && tx_idle && cyc > 2) && cyc < 20) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      cyc++;
    end
    check("t1_all_sent", 32'(all_sent), 32'd1);

    // Slow transmitter, 16 back-to-back writes.
    do_reset();
    busy_len = 20;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    drain_until(16, 800, "t2_count");
    for (int i = 0; i < 16 && i < rx.size(); i++) check($sformatf("t2_byte%0d", i), 32'(rx[i]), 32'(i));
    check("t2_pulses", 32'(req_count), 32'd16);

    // Overflow with transmitter held busy.
    do_reset();
    tx_override = 1'b1;
    tx_idle = 1'b0;
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    check("t3_level", 32'(level),    32'd16);
    check("t3_full",  32'(full),     32'd1);
    check("t3_ovf",   32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check("t3_set_wins", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t3_ovf_clr2", 32'(overflow), 32'd0);
    tx_override = 1'b0;
    tx_idle = 1'b1;
    busy_len = 2;
    drain_until(16, 400, "t3_count");
    idle_cycles(20);
    check("t3_no_extra", 32'(rx.size()), 32'd16);
    for (int i = 0; i < 16 && i < rx.size(); i++) check($sformatf("t3_byte%0d", i), 32'(rx[i]), 32'(8'h80 + i));

    // Write and pop in the same cycle, then a long stream across pointer wrap.
    do_reset();
    sent.delete();
    tx_override = 1'b1;
    tx_idle = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      step(1'b1, b, 1'b0, 1'b0);
    end
    tx_idle = 1'b1;
    b = 8'($urandom);
    sent.push_back(b);
    step(1'b1, b, 1'b0, 1'b0);
    check("t4_level_same", 32'(level),      32'd5);
    check("t4_pop",        32'(tx_request), 32'd1);
    tx_override = 1'b0;
    while (sent.size() < 40) begin
      busy_len = $urandom_range(0, 3);
      if (($urandom % 2 == 1) && q.size() < int'(DEPTH)) begin
        b = 8'($urandom);
        sent.push_back(b);
        step(1'b1, b, 1'b0, 1'b0);
      end else begin
        step(1'b0, 8'h00, 1'b0, 1'b0);
      end
    end
    drain_until(40, 600, "t4_count");
    for (int i = 0; i < 40 && i < rx.size(); i++) check($sformatf("t4_byte%0d", i), 32'(rx[i]), 32'(sent[i]));

    // Flush while a byte is in flight.
    do_reset();
    busy_len = 10;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    cyc = 0;
    while (tx_idle && cyc < 20) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      cyc++;
    end
    check("t5_in_wait", 32'(tx_idle), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    idle_cycles(40);
    check("t5_pulses",   32'(req_count), 32'd1);
    check("t5_inflight", 32'(rx.size() > 0 ? rx[0] : 8'hFF), 32'h00A0);

    // Reset asserted in the middle of a transfer.
    do_reset();
    busy_len = 10;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t6_pre_level", 32'(level), 32'd3);
    check("t6_pre_busy",  32'(tx_idle), 32'd0);
    rst_n = 1'b0;
    tx_idle = 1'b1; busy_cnt = 0; req_seen = 1'b0;
    model_reset();
    #1;
    check("t6_req",      32'(tx_request), 32'd0);
    check("t6_level",    32'(level),      32'd0);
    check("t6_all_sent", 32'(all_sent),   32'd1);
    @(posedge clk_bus);
    #2;
    rst_n = 1'b1;
    req_count = 0;
    rx.delete();
    idle_cycles(10);
    check("t6_no_req", 32'(req_count), 32'd0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    drain_until(1, 20, "t6_new_byte");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) busy_len = $urandom_range(0, 4);
      step(($urandom % 3) != 0, 8'($urandom), ($urandom % 40) == 0, ($urandom % 16) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_fifo
